pipe_deser: RTL and testbench

Serial-to-parallel receiver at the far end of the 1-bit `pipeline`/`pipestage` delay chain. It frames the single-bit stream leaving the last stage into WIDTH-bit words. Each word is presented on a valid/ready output with a one-word holding register. Overrun and framing errors are flagged.

---
 rtl/pipe_deser.sv | 111 +++++++++++
 tb/tb_pipe_deser.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_deser.sv
// pipe_deser -- serial-to-parallel receiver for the 1-bit pipeline delay chain.
//
// Frames the bit stream leaving the last pipeline stage into WIDTH-bit words:
// start bit (1), WIDTH data bits LSB first, stop bit (0); the line idles at 0.
// Each completed word goes into a one-word holding register presented on a
// valid/ready interface.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in         in   serial line
//   out_data   out  received word (first data bit in bit 0)
//   out_valid  out  holding register holds an unconsumed word
//   out_ready  in   consumer accepts when out_valid & out_ready
//   overrun    out  1-cycle pulse: completed word dropped, holding reg full
//   frame_err  out  1-cycle pulse: stop bit was 1, word discarded
module pipe_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        // A word accepted this cycle leaves the register; a commit below may refill it.
        valid_d = valid_q & ~out_ready;
        ovr_d   = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) shreg_d[i] = in;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
            end
            STOP: begin
                // Always back to IDLE: a 1 seen here is a bad stop bit, not a new start.
                state_d = IDLE;
                if (in) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || out_ready) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_pipe_deser.sv
// Directed bench for pipe_deser (WIDTH=8). Inputs change #1 after the rising
// edge, outputs are checked at that same point, so each check sees the
// registers updated by the edge just taken.
module tb_pipe_deser;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         din = 1'b0;
    logic         pin = 1'b0;
    logic         use_pipe = 1'b0;
    logic [2:0]   pipe_q = '0;
    logic         line;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         overrun;
    logic         frame_err;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    // Stand-in for the 3-stage 1-bit pipeline feeding the receiver.
    always @(posedge clock) pipe_q <= {pipe_q[1:0], pin};
    assign line = use_pipe ? pipe_q[2] : din;

    pipe_deser #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (line),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick();
    endtask

    task automatic send_head(input logic [W-1:0] d);
        send_bit(1'b1);
        for (int i = 0; i < W; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop);
        send_head(d);
        send_bit(stop);
    endtask

    initial begin
        int lat;
        logic [9:0] e2e_bits;

        // Reset
        reset_n = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        reset_n = 1'b1;
        send_bit(1'b0); send_bit(1'b0);

        // Single frame A5, ready high: word appears right after the stop-bit edge
        out_ready = 1'b1;
        send_head(8'hA5);
        chk("a5_not_yet", 32'(out_valid), 32'd0);
        send_bit(1'b0);
        chk("a5_valid", 32'(out_valid), 32'd1);
        chk("a5_data",  32'(out_data),  32'hA5);
        send_bit(1'b0);
        chk("a5_one_cycle", 32'(out_valid), 32'd0);

        // Back-to-back 3C, C3 with consumer stalled
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_data",  32'(out_data),  32'h3C);
        chk("b2b_first_noovr", 32'(overrun),   32'd0);
        send_frame(8'hC3, 1'b0);
        chk("b2b_ovr",       32'(overrun),   32'd1);
        chk("b2b_hold_data", 32'(out_data),  32'h3C);
        chk("b2b_hold_vld",  32'(out_valid), 32'd1);
        send_bit(1'b0);
        chk("b2b_ovr_pulse", 32'(overrun),  32'd0);
        chk("b2b_still_3c",  32'(out_data), 32'h3C);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("b2b_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Accept and commit in the same cycle
        send_frame(8'h7E, 1'b0);
        chk("sim_hold_7e", 32'(out_data), 32'h7E);
        send_head(8'h81);
        chk("sim_still_7e", 32'(out_data), 32'h7E);
        out_ready = 1'b1;
        send_bit(1'b0);
        out_ready = 1'b0;
        chk("sim_noovr", 32'(overrun),   32'd0);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_data",  32'(out_data),  32'h81);
        send_bit(1'b0);
        chk("sim_stable", 32'(out_data),  32'h81);
        chk("sim_held",   32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("sim_drained", 32'(out_valid), 32'd0);

        // Framing error, then a good frame right after
        send_frame(8'hFF, 1'b1);
        chk("fe_pulse", 32'(frame_err), 32'd1);
        chk("fe_novld", 32'(out_valid), 32'd0);
        chk("fe_noovr", 32'(overrun),   32'd0);
        send_bit(1'b0);
        chk("fe_one_cycle", 32'(frame_err), 32'd0);
        chk("fe_novld2",    32'(out_valid), 32'd0);
        out_ready = 1'b0;
        send_frame(8'h01, 1'b0);
        chk("fe_next_valid", 32'(out_valid), 32'd1);
        chk("fe_next_data",  32'(out_data),  32'h01);

        // Reset mid-frame while 01 is still held
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        send_bit(1'b0);
        reset_n = 1'b1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data",  32'(out_data),  32'd0);
        chk("mr_ovr",   32'(overrun),   32'd0);
        chk("mr_ferr",  32'(frame_err), 32'd0);
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        chk("mr_no_partial", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b0);
        chk("mr_5a_valid", 32'(out_valid), 32'd1);
        chk("mr_5a_data",  32'(out_data),  32'h5A);
        send_bit(1'b0);

        // End-to-end through the 3-stage chain: count cycles from the start bit entering
        use_pipe = 1'b1;
        e2e_bits = {1'b0, 8'hA5, 1'b1};
        tick(); tick(); tick();
        lat = 0;
        pin = e2e_bits[0];
        for (int n = 1; n <= 20; n++) begin
            tick();
            pin = (n < 10) ? e2e_bits[n] : 1'b0;
            if (out_valid && lat == 0) begin
                lat = n;
                chk("e2e_data", 32'(out_data), 32'hA5);
            end
        end
        chk("e2e_latency", 32'(lat), 32'd13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
